// File: rtl/qadd_accum_seq_pkg.sv
// Shared types and default sizing for the time-multiplexed sign-magnitude accumulator.
package qadd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WORD_LENGTH = 11;
  localparam int DEF_NUM_TERMS   = 9;

  localparam int              MAG_W   = DEF_WORD_LENGTH - 1;
  localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};
  localparam int              IDX_W   = $clog2(DEF_NUM_TERMS);

endpackage

// File: rtl/qadd_accum_seq_if.sv
// Window-in / sum-out handshake bundle; slave is the accumulator, master the driver.
interface qadd_accum_seq_if #(
  parameter int W = 11,
  parameter int N = 9
);
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_terms;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_sum;
  logic           out_ovf;
  logic           busy;

  modport slave (
    input  flush, in_valid, in_terms, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport master (
    output flush, in_valid, in_terms, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/qadd_accum_seq_ovf.sv
// Sign-magnitude adder with overflow flag; saturates or wraps the magnitude on carry
// and never returns negative zero.
module qadd_ovf
  import qadd_pkg::*;
#(
  parameter int FP_WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int SATURATE       = 1
) (
  input  logic [FP_WORD_LENGTH-1:0] a,
  input  logic [FP_WORD_LENGTH-1:0] b,
  output logic [FP_WORD_LENGTH-1:0] c,
  output logic                      ovf
);

  localparam int MW = FP_WORD_LENGTH - 1;

  logic          sa, sb, sign;
  logic [MW-1:0] ma, mb, mag;
  logic [MW:0]   sum;

  assign sa  = a[MW];
  assign sb  = b[MW];
  assign ma  = a[MW-1:0];
  assign mb  = b[MW-1:0];
  assign sum = {1'b0, ma} + {1'b0, mb};

  always_comb begin
    ovf  = 1'b0;
    sign = sa;
    mag  = sum[MW-1:0];
    if (sa == sb) begin
      if (sum[MW]) begin
        ovf = 1'b1;
        if (SATURATE != 0) mag = {MW{1'b1}};
      end
    end else if (ma >= mb) begin
      mag  = ma - mb;
      sign = sa;
    end else begin
      mag  = mb - ma;
      sign = sb;
    end
    // Zero magnitude is always reported as +0.
    if (mag == '0) sign = 1'b0;
  end

  assign c = {sign, mag};

endmodule

// File: rtl/qadd_accum_seq.sv
// Sums NUM_TERMS sign-magnitude terms of one window using a single shared adder,
// one term per cycle, with sticky overflow reporting.
//
// state | meaning
// IDLE  | waiting for a window, in_ready high
// ACCUM | adding term[idx] into acc each cycle
// DONE  | sum presented on out_*, held until out_ready
module qadd_accum_seq
  import qadd_pkg::*;
#(
  parameter int FP_WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int FP_FRAC_LENGTH = 0,
  parameter int NUM_TERMS      = DEF_NUM_TERMS,
  parameter int SATURATE       = 1
) (
  input logic            aclk,
  input logic            aresetn,
  qadd_accum_seq_if.slave bus
);

  localparam int W  = FP_WORD_LENGTH;
  localparam int IW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [NUM_TERMS*W-1:0] terms;
  logic [W-1:0]           acc;
  logic                   ovf;
  logic                   out_valid_q;
  logic [W-1:0]           out_sum_q;
  logic                   out_ovf_q;

  logic [W-1:0] term_cur, add_a, add_b, add_c;
  logic         add_ovf, take;

  assign term_cur = terms[idx*W +: W];

  // Outside ACCUM the adder normalizes the incoming term0 (x + 0), so the
  // accept path shares the same datapath.
  assign add_a = (state == ACCUM) ? acc : bus.in_terms[W-1:0];
  assign add_b = (state == ACCUM) ? term_cur : '0;

  qadd_ovf #(
    .FP_WORD_LENGTH(W),
    .SATURATE      (SATURATE)
  ) u_add (
    .a  (add_a),
    .b  (add_b),
    .c  (add_c),
    .ovf(add_ovf)
  );

  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign take          = bus.in_valid && bus.in_ready;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      idx         <= '0;
      terms       <= '0;
      acc         <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      idx         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (take) begin
            terms       <= bus.in_terms;
            acc         <= add_c;
            ovf         <= 1'b0;
            idx         <= IW'(1);
            out_valid_q <= 1'b0;
            state       <= ACCUM;
          end else if (state == DONE && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        ACCUM: begin
          acc <= add_c;
          ovf <= ovf | add_ovf;
          idx <= idx + 1'b1;
          if (idx == IW'(NUM_TERMS - 1)) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= add_c;
            out_ovf_q   <= ovf | add_ovf;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qadd_accum_seq.sv
// Directed bench: a saturating and a wrapping instance driven with the same stimulus.
module tb_qadd_accum_seq;
  import qadd_pkg::*;

  localparam int W = 11;
  localparam int N = 9;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 aclk = ~aclk;

  qadd_accum_seq_if #(.W(W), .N(N)) bus ();
  qadd_accum_seq_if #(.W(W), .N(N)) bus_w ();

  assign bus_w.flush     = bus.flush;
  assign bus_w.in_valid  = bus.in_valid;
  assign bus_w.in_terms  = bus.in_terms;
  assign bus_w.out_ready = bus.out_ready;

  qadd_accum_seq #(.FP_WORD_LENGTH(W), .FP_FRAC_LENGTH(0), .NUM_TERMS(N), .SATURATE(1))
    dut_sat (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  qadd_accum_seq #(.FP_WORD_LENGTH(W), .FP_FRAC_LENGTH(0), .NUM_TERMS(N), .SATURATE(0))
    dut_wrap (.aclk(aclk), .aresetn(aresetn), .bus(bus_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Accepts one window and runs until out_valid; leaves the DUT in DONE.
  task automatic run_window(input string tag, input logic [N*W-1:0] t,
                            input logic [W-1:0] exp_s, input logic exp_o,
                            input logic [W-1:0] exp_sw, input logic exp_ow);
    int cnt;
    bus.in_terms = t;
    bus.in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_terms = '1;
    cnt = 0;
    while (!bus.out_valid && cnt < 30) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd8);
    chk({tag, "_sum_sat"}, 32'(bus.out_sum), 32'(exp_s));
    chk({tag, "_ovf_sat"}, 32'(bus.out_ovf), 32'(exp_o));
    chk({tag, "_sum_wrap"}, 32'(bus_w.out_sum), 32'(exp_sw));
    chk({tag, "_ovf_wrap"}, 32'(bus_w.out_ovf), 32'(exp_ow));
  endtask

  initial begin
    int busy_ok;
    int stable_ok;
    int seen_valid;
    logic [W-1:0] held;

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_terms  = '0;
    bus.out_ready = 1'b1;

    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    #10;
    aresetn = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Nine +1 terms; busy must stay high through the whole accumulation.
    bus.in_terms = {9{11'h001}};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    busy_ok = 1;
    for (int i = 1; i <= 8; i++) begin
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (i < 8) tick();
      else begin
        if (bus.out_valid === 1'b1) busy_ok = 0;
        tick();
      end
    end
    chk("ones_busy", 32'(busy_ok), 32'd1);
    chk("ones_valid_at_8", 32'(bus.out_valid), 32'd1);
    chk("ones_busy_done", 32'(bus.busy), 32'd1);
    chk("ones_sum", 32'(bus.out_sum), 32'h009);
    chk("ones_ovf", 32'(bus.out_ovf), 32'd0);
    tick();
    chk("ones_ack_valid", 32'(bus.out_valid), 32'd0);
    chk("ones_ack_busy", 32'(bus.busy), 32'd0);

    run_window("neg", {{8{11'h401}}, 11'h005}, 11'h403, 1'b0, 11'h403, 1'b0);
    tick();
    run_window("ovf", {{7{11'h000}}, 11'h064, 11'h3E8}, 11'h3FF, 1'b1, 11'h04C, 1'b1);
    tick();
    run_window("negz", {{8{11'h000}}, 11'h400}, 11'h000, 1'b0, 11'h000, 1'b0);
    tick();
    run_window("cancel", {{7{11'h000}}, 11'h407, 11'h007}, 11'h000, 1'b0, 11'h000, 1'b0);
    tick();

    // Backpressure: hold DONE for 5 cycles, then chain the next window.
    bus.out_ready = 1'b0;
    run_window("hold", {{4{11'h001}}, {5{11'h003}}}, 11'h013, 1'b0, 11'h013, 1'b0);
    held = bus.out_sum;
    stable_ok = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_sum !== held || bus.out_ovf !== 1'b0 ||
          bus.in_ready !== 1'b0) stable_ok = 0;
    end
    chk("hold_stable", 32'(stable_ok), 32'd1);
    chk("hold_sum", 32'(held), 32'h013);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_terms  = {9{11'h002}};
    #1;
    chk("chain_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_terms = '1;
    begin
      int cnt = 0;
      while (!bus.out_valid && cnt < 30) begin
        tick();
        cnt++;
      end
      chk("chain_latency", 32'(cnt), 32'd8);
    end
    chk("chain_sum", 32'(bus.out_sum), 32'h012);
    tick();

    // Reset in the middle of a window.
    bus.in_terms = {9{11'h003}};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    aresetn = 1'b0;
    #2;
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    aresetn = 1'b1;
    tick();
    run_window("after_rst", {9{11'h002}}, 11'h012, 1'b0, 11'h012, 1'b0);
    tick();

    // Flush in the middle of a window: no output may appear afterwards.
    bus.in_terms = {9{11'h005}};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid !== 1'b0) seen_valid = 1;
      tick();
    end
    chk("flush_no_output", 32'(seen_valid), 32'd0);

    // flush with in_valid in IDLE must not accept.
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_terms = {9{11'h007}};
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_idle_busy", 32'(bus.busy), 32'd0);
    run_window("after_flush", {9{11'h002}}, 11'h012, 1'b0, 11'h012, 1'b0);
    tick();
    chk("final_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qadd_accum_seq.md
Name: qadd_accum_seq

Overview:
- Time-multiplexed accumulator controller that sequences one sign-magnitude fixed-point adder to sum the NUM_TERMS signed products of a convolution window, such as a 3x3 Sobel kernel.
- Sits between the kernel multiplier stage and the pixel output stage in the AXI convolution IP.
- Replaces a tree of NUM_TERMS-1 adders with one adder plus a small FSM, trading throughput for area.
- Adds the overflow detection and saturation that the bare adder lacks.

Parameters:
- FP_WORD_LENGTH, 11, total word width in bits; MSB is the sign bit, the remaining bits are magnitude.
- FP_FRAC_LENGTH, 0, fractional bits; informational only, since addition is binary-point agnostic.
- NUM_TERMS, 9, number of terms summed per window; legal range 2..16.
- SATURATE, 1, 1 = clamp magnitude on overflow, 0 = wrap magnitude (truncate carry).

Ports:
- aclk  in  1  clock, rising edge.
- aresetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; discards any window in progress.
- in_valid  in  1  window terms valid.
- in_ready  out  1  block can accept a window.
- in_terms  in  NUM_TERMS*FP_WORD_LENGTH  packed sign-magnitude terms; term k occupies bits [k*W +: W].
- out_valid  out  1  sum valid.
- out_ready  in  1  downstream accepts the sum.
- out_sum  out  FP_WORD_LENGTH  sign-magnitude sum.
- out_ovf  out  1  at least one add in this window overflowed.
- busy  out  1  high in ACCUM and DONE.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - state=IDLE, idx=0, acc=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
  - in_ready reads 1 once aresetn deasserts.
  - Reset mid-window drops the window silently; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid: capture in_terms into the term register, acc<=normalize(term0), ovf<=0, idx<=1, go to ACCUM.
  - ACCUM: each cycle {acc,ovf_add}<=add(acc, term[idx]); ovf<=ovf|ovf_add; idx<=idx+1. After the add that uses idx=NUM_TERMS-1, go to DONE.
  - DONE: out_valid=1, out_sum=acc, out_ovf=ovf; all three stay stable until out_valid&&out_ready.
    - On handshake with in_valid=0: go to IDLE.
    - On handshake with in_valid=1: accept the new window in the same cycle, exactly as the IDLE accept, and go to ACCUM.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready.
- in_terms is sampled only on the accept edge; later changes to it are ignored.
- Latency: out_valid rises NUM_TERMS-1 cycles after the accept edge (8 for the default).
- Throughput: one window per NUM_TERMS cycles with back-to-back handshakes.
- add() rules:
  - Same signs: magnitude = ma+mb with a W-bit carry.
    - Carry set: ovf_add=1; magnitude = all ones if SATURATE=1, else the low W-1 bits; sign kept.
  - Opposite signs: result = larger magnitude minus smaller, sign of the larger operand; ovf_add=0.
  - Equal magnitudes with opposite signs give +0.
  - A -0 result is never produced; normalize() maps 0x400 (for W=11) to 0x000.
  - Input -0 terms are legal and behave as 0.
- flush:
  - Takes priority over everything except reset; takes effect at the next edge.
  - Goes to IDLE, out_valid=0, idx=0; no output is produced.
  - flush together with in_valid in IDLE: the window is not accepted.
- busy = (state != IDLE).

Decomposition:
- Package qadd_pkg holds:
  - state encoding IDLE=2'd0, ACCUM=2'd1, DONE=2'd2;
  - helper constants MAG_W = FP_WORD_LENGTH-1 and MAG_MAX = {MAG_W{1'b1}};
  - IDX_W = clog2(NUM_TERMS).
- One combinational sub-module, qadd_ovf (ports a, b, c, ovf, parameters FP_WORD_LENGTH, SATURATE), implements add() including normalization.
- The top level holds only the FSM, the index counter, the term register and the output register.

Test Plan:
- Nine terms of +1 (0x001), accept at cycle 0 -> out_valid at cycle 8, out_sum=0x009, out_ovf=0, busy high in cycles 1-8.
- term0=+5 (0x005), terms 1-8 = -1 (0x401) -> out_sum=0x403 (-3), out_ovf=0.
- term0=+1000 (0x3E8), term1=+100 (0x064), rest 0 -> SATURATE=1: out_sum=0x3FF, out_ovf=1; SATURATE=0: out_sum=0x04C, out_ovf=1.
- term0=-0 (0x400), rest +0; also term0=+7, term1=-7 (0x407), rest 0 -> out_sum=0x000 in both cases, never 0x400.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid/out_sum/out_ovf stable and in_ready=0. Then out_ready=1 with in_valid=1 -> in_ready=1 that cycle, next window accepted, next out_valid exactly 8 cycles later.
- Drive aresetn=0, then separately flush=1, at idx=4 of a window -> out_valid stays 0, state IDLE, in_ready=1; the next window (all +2) yields 0x012 with no carry-over from the aborted window.
